// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 8;

  // Bit counter width: $clog2(w), but never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor
  import serial_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow generate/propagate.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = (a - b) mod 2^WIDTH over WIDTH
// cycles, using one full_subtractor cell and a registered borrow.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic             bw_q, bw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             bit_d;
  logic             bit_bout;
  logic             last_bit;
  logic             load;
  logic [WIDTH-1:0] d_msb;
  logic [WIDTH-1:0] r_next;

  full_subtractor u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (bw_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // Operation-level decodes: final bit, operand acceptance, next result word.
  always_comb begin
    last_bit        = (cnt_q == CNT_LAST);
    load            = start && ((state_q == IDLE) || (state_q == DONE));
    d_msb           = '0;
    d_msb[WIDTH-1]  = bit_d;
    r_next          = (r_sr_q >> 1) | d_msb;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start during SHIFT is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  // Datapath next values: load on accept, shift one bit per SHIFT cycle,
  // publish result on the last bit.
  always_comb begin
    cnt_d  = cnt_q;
    a_sr_d = a_sr_q;
    b_sr_d = b_sr_q;
    r_sr_d = r_sr_q;
    bw_d   = bw_q;
    diff_d = diff_q;
    bout_d = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (load) begin
      cnt_d  = '0;
      a_sr_d = a;
      b_sr_d = b;
      r_sr_d = '0;
      bw_d   = 1'b0;
    end else if (state_q == SHIFT) begin
      a_sr_d = a_sr_q >> 1;
      b_sr_d = b_sr_q >> 1;
      r_sr_d = r_next;
      bw_d   = bit_bout;
      if (last_bit) begin
        // Counter holds at its last value so it never wraps.
        diff_d = r_next;
        bout_d = bit_bout;
`ifdef SERIAL_SUB_OVF_EN
        // Operand LSBs are the original sign bits on this cycle.
        ovf_d  = (a_sr_q[0] ^ b_sr_q[0]) & (bit_d ^ a_sr_q[0]);
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      a_sr_q <= '0;
      b_sr_q <= '0;
      r_sr_q <= '0;
      bw_q   <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      a_sr_q <= a_sr_d;
      b_sr_q <= b_sr_d;
      r_sr_q <= r_sr_d;
      bw_q   <= bw_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH = 8): table vectors, hand-written
// multi-cycle sequences and randomized operations against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present operands at a falling edge, let the next rising edge accept them,
  // then withdraw start and scramble the operand inputs.
  task automatic start_op(input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(negedge clk);
    start = 1'b1;
    a = aa;
    b = bb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  // Called #1 after the accepting edge; counts edges until done and busy samples.
  task automatic wait_done(output int lat, output int bc);
    bc  = busy ? 1 : 0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (busy) bc++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ed, input logic eb, input logic eo);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("note: unknown ovf expectation");
`endif
  endtask

  initial begin
    int lat, bc, ndone;
    int sa, sb, sd;
    logic [W-1:0] ra, rb, md;
    logic mb, mo;

    tbl[0] = '{8'h5A, 8'h23, 8'h37, 1'b0, 1'b0};
    tbl[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{8'h09, 8'h04, 8'h05, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    tbl[7] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};

    // Reset state
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      start_op(tbl[i].a, tbl[i].b);
      wait_done(lat, bc);
      chk($sformatf("tbl%0d_lat", i), lat, 8);
      chk($sformatf("tbl%0d_busy", i), bc, 8);
      check_result($sformatf("tbl%0d", i), tbl[i].diff, tbl[i].bout, tbl[i].ovf);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_done_pulse", i), done, 0);
      chk($sformatf("tbl%0d_idle", i), busy, 0);
    end

    // start during SHIFT is ignored
    start_op(8'h05, 8'h03);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin start = 1'b1; a = 8'hFF; b = 8'h00; end
      if (lat == 5) start = 1'b0;
      if (done) break;
    end
    start = 1'b0;
    chk("ign_done_seen", done, 1);
    chk("ign_lat", lat, 8);
    check_result("ign", 8'h02, 1'b0, 1'b0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("ign_no_second_done", ndone, 0);

    // Reset mid-operation
    start_op(8'h5A, 8'h23);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_bout", bout, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(8'hFF, 8'hFF);
    wait_done(lat, bc);
    chk("postrst_lat", lat, 8);
    check_result("postrst", 8'h00, 1'b0, 1'b0);

    // Back-to-back: restart in the DONE cycle
    start_op(8'h01, 8'h02);
    wait_done(lat, bc);
    check_result("b2b_first", 8'hFF, 1'b1, 1'b0);
    start = 1'b1;
    a = 8'h09;
    b = 8'h04;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy_again", busy, 1);
    check_result("b2b_hold", 8'hFF, 1'b1, 1'b0);
    wait_done(lat, bc);
    chk("b2b_gap", lat + 1, 9);
    check_result("b2b_second", 8'h05, 1'b0, 1'b0);

    // Randomized operations against arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i == 0) begin ra = 8'h80; rb = 8'h7F; end
      if (i == 1) begin ra = 8'h7F; rb = 8'h80; end
      sa = int'($signed(ra));
      sb = int'($signed(rb));
      sd = sa - sb;
      md = W'(int'(ra) - int'(rb));
      mb = (int'(ra) < int'(rb));
      mo = (sd > 127) || (sd < -128);
      start_op(ra, rb);
      wait_done(lat, bc);
      chk($sformatf("rnd%0d_lat", i), lat, 8);
      check_result($sformatf("rnd%0d", i), md, mb, mo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, LSB-first N-bit subtractor computing `diff = a - b` over WIDTH cycles, built around a single 1-bit full-subtractor cell with a registered borrow. It is the inverse-operation counterpart of the adder datapath. It is used where area matters more than latency, and it sits behind a simple start/done handshake so a controller or bench can sequence operations.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be at least 1.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `start` in 1: request pulse; `a`/`b` are sampled on the edge where `start` is accepted.
- `a` in WIDTH: minuend.
- `b` in WIDTH: subtrahend.
- `busy` out 1: high while bits are being processed.
- `done` out 1: one-cycle pulse when the result is valid.
- `diff` out WIDTH: result `(a - b) mod 2^WIDTH`; held until the next completion.
- `bout` out 1: final borrow, equal to unsigned `a < b`; held with `diff`.
- `ovf` out 1: signed overflow flag. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- States are `IDLE`, `SHIFT`, `DONE`.
- **IDLE**:
  - `start` = 1 loads `a` and `b` into internal shift registers, clears the borrow register and clears the bit counter.
  - Next state is `SHIFT`.
- **SHIFT**, once per cycle:
  - Take the LSBs a0 and b0 and the registered borrow bw.
  - Compute `d = a0 ^ b0 ^ bw`.
  - Compute the next borrow as `(~a0 & b0) | (~(a0 ^ b0) & bw)`.
  - Shift the operand registers right.
  - Shift `d` into the MSB of the internal result shift register.
  - Increment the counter.
  - When the counter equals WIDTH-1, copy the completed result into `diff` and the final borrow into `bout`, then move to `DONE`.
- **DONE**:
  - `done` = 1 for exactly this cycle.
  - `start` = 1 here is accepted exactly as in `IDLE` and goes to `SHIFT`, allowing back-to-back operations.
  - Otherwise the next state is `IDLE`.
- `start` while in `SHIFT` is ignored; the operands of the in-flight operation are unaffected.
- `busy` = (state == `SHIFT`). `done` = (state == `DONE`). Both are decoded from registered state, so there is no combinational path from inputs.
- `diff` and `bout` change only on the transition from `SHIFT` to `DONE`. During an operation they hold the previous result.
- Counter width is `$clog2(WIDTH)` with a minimum of 1. It never wraps within an operation.
- With WIDTH = 1, `SHIFT` lasts exactly one cycle.

## Timing
- Reset (`rst_n` low, asynchronous): state `IDLE`; `busy` = 0, `done` = 0, `diff` = 0, `bout` = 0, `ovf` = 0; counter, borrow and shift registers all 0.
- Reset asserted mid-operation discards the partial result. Operation resumes normally from `IDLE` after reset is released.
- Latency:
  - Call the edge that accepts `start` edge 0.
  - `busy` is high from edge 0 to edge WIDTH.
  - `done` is high from edge WIDTH to edge WIDTH+1.
  - `diff` and `bout` are valid from edge WIDTH onward.
- Throughput is one operation per WIDTH+1 cycles when `start` is reissued during `DONE`.
- `a` and `b` need to be stable only at the accepting edge.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- **Defined**:
  - The `ovf` port exists.
  - On the final `SHIFT` cycle (a0 and b0 are the original MSBs), `ovf` is registered as `(a0 ^ b0) & (d ^ a0)`.
  - `ovf` updates and holds together with `diff`, and resets to 0.
- **Undefined**: the `ovf` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `serial_sub_pkg` holds:
  - the state enum `sub_state_t` (`IDLE`, `SHIFT`, `DONE`);
  - the default width constant `SUB_WIDTH_DEFAULT` = 8.
- Sub-module `full_subtractor` is the combinational 1-bit cell:
  - inputs `a`, `b`, `bin`;
  - outputs `d`, `bout`.
- The top level instantiates `full_subtractor` once and owns the FSM, counter, shift registers and borrow flop.

## Test plan
All scenarios use WIDTH = 8.
- `a`=0x5A, `b`=0x23, `start` pulse -> `done` exactly 8 edges after the accepting edge; `diff`=0x37, `bout`=0; `busy` high for 8 cycles.
- `a`=0x10, `b`=0x20 -> `diff`=0xF0, `bout`=1, `ovf`=0.
- `a`=0x80, `b`=0x01 -> `diff`=0x7F, `bout`=0; `ovf`=1 with the macro defined, port absent without it.
- Start 0x05 - 0x03, then assert `start` with 0xFF/0x00 during cycles 2–5 of `SHIFT` -> result is 0x02 with `bout`=0, and no second `done` appears.
- Drop `rst_n` at cycle 4 of an operation -> `busy`, `done`, `diff`, `bout` are all 0 immediately. After release, 0xFF - 0xFF -> `diff`=0x00, `bout`=0.
- Issue 0x01 - 0x02, then assert `start` with 0x09 - 0x04 in the `DONE` cycle -> first result 0xFF with `bout`=1; second `done` 9 edges later with `diff`=0x05, `bout`=0.
